lsu_ctrl: RTL and testbench

//   Load/store initiator in front of the 24-bit data memory (byte array, 3-byte big-endian word at
//   add..add+2, combinational read, write of all 3 bytes on posedge clk when wen).

---
 rtl/lsu_ctrl.sv | 156 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of a 24-bit word, byte-addressed data memory.
// Handles byte/half/word loads with zero/sign extension and performs
// read-modify-write for partial stores, since the memory only writes whole words.
// Every access is range-checked before the memory is touched.
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// READ  | memory read of the latched address (load or partial-store merge)
// WRITE | dm_wen asserted for this single cycle
// RESP  | response held until rsp_ready
module lsu_ctrl #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [23:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [23:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] dm_add,
  output logic [23:0]       dm_data_in,
  output logic              dm_wen,
  input  logic [23:0]       dm_data_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(MEM_BYTES - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic              sgn_q, sgn_d;
  logic [23:0]       wdata_q, wdata_d;
  logic [23:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [ADDR_W:0]   last_addr;
  logic              acc_err;
  logic [23:0]       load_val;
  logic [23:0]       merge_val;

  // Range check one bit wider than the address so a wrap past the top counts as out of range.
  always_comb begin
    last_addr = {1'b0, req_addr} + {{(ADDR_W-1){1'b0}}, req_size};
    acc_err   = (req_size == 2'd3) || (last_addr > LAST_BYTE);
  end

  // Load extraction from the MSB end of the read word, and store merge for partial writes.
  always_comb begin
    load_val  = dm_data_out;
    merge_val = wdata_q;
    case (size_q)
      2'd0: begin
        load_val  = sgn_q ? {{16{dm_data_out[23]}}, dm_data_out[23:16]}
                          : {16'h0000, dm_data_out[23:16]};
        merge_val = {wdata_q[7:0], dm_data_out[15:0]};
      end
      2'd1: begin
        load_val  = sgn_q ? {{8{dm_data_out[23]}}, dm_data_out[23:8]}
                          : {8'h00, dm_data_out[23:8]};
        merge_val = {wdata_q[15:0], dm_data_out[7:0]};
      end
      default: begin
        load_val  = dm_data_out;
        merge_val = wdata_q;
      end
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          we_d    = req_we;
          sgn_d   = req_signed;
          wdata_d = req_wdata;
          rdata_d = 24'h000000;
          err_d   = acc_err;
          if (acc_err)                         state_d = S_RESP;
          else if (!req_we || req_size != 2'd2) state_d = S_READ;
          else                                 state_d = S_WRITE;
        end
      end
      S_READ: begin
        if (we_q) begin
          wdata_d = merge_val;
          state_d = S_WRITE;
        end else begin
          rdata_d = load_val;
          state_d = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      default: if (rsp_ready) state_d = S_IDLE;
    endcase
  end

  // State and datapath flops with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= 2'd0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      wdata_q <= 24'h000000;
      rdata_q <= 24'h000000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    rsp_valid  = (state_q == S_RESP);
    dm_wen     = (state_q == S_WRITE);
    rsp_rdata  = rdata_q;
    rsp_err    = err_q;
    dm_add     = addr_q;
    dm_data_in = wdata_q;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array memory model, directed requests with
// hand-computed expectations pushed to a scoreboard, and a monitor that
// checks each response's latency, payload and stability.
module tb_lsu_ctrl;

  localparam int MEM_BYTES = 256;
  localparam int ADDR_W    = 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_we, req_signed;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [23:0]       req_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [23:0]       rsp_rdata;
  logic [ADDR_W-1:0] dm_add;
  logic [23:0]       dm_data_in, dm_data_out;
  logic              dm_wen;

  lsu_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .dm_add(dm_add), .dm_data_in(dm_data_in), .dm_wen(dm_wen),
    .dm_data_out(dm_data_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: combinational 3-byte big-endian read, whole-word write.
  logic [7:0] mem [0:MEM_BYTES-1];
  int         wen_cnt = 0;
  logic [ADDR_W-1:0] wen_add;
  logic [23:0]       wen_data;

  always_comb begin
    dm_data_out = 24'h000000;
    if (int'(dm_add) < MEM_BYTES)     dm_data_out[23:16] = mem[int'(dm_add)];
    if (int'(dm_add) + 1 < MEM_BYTES) dm_data_out[15:8]  = mem[int'(dm_add) + 1];
    if (int'(dm_add) + 2 < MEM_BYTES) dm_data_out[7:0]   = mem[int'(dm_add) + 2];
  end

  always @(posedge clk) begin
    if (dm_wen) begin
      if (int'(dm_add) < MEM_BYTES)     mem[int'(dm_add)]     <= dm_data_in[23:16];
      if (int'(dm_add) + 1 < MEM_BYTES) mem[int'(dm_add) + 1] <= dm_data_in[15:8];
      if (int'(dm_add) + 2 < MEM_BYTES) mem[int'(dm_add) + 2] <= dm_data_in[7:0];
      wen_cnt  <= wen_cnt + 1;
      wen_add  <= dm_add;
      wen_data <= dm_data_in;
    end
  end

  // Scoreboard entries: expected payload and the cycle rsp_valid must first appear.
  typedef struct {
    logic [23:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  bit   in_rsp = 0;

  // Monitor: new responses are popped and checked; held responses must stay stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_rsp = 0;
    end else if (rsp_valid) begin
      if (!in_rsp) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%0h err=%0b with nothing expected", rsp_rdata, rsp_err);
        end else begin
          cur = sb.pop_front();
          chk("rsp_latency_cycle", cyc, cur.cyc);
          chk("rsp_rdata", {8'h00, rsp_rdata}, {8'h00, cur.rdata});
          chk("rsp_err", {31'h0, rsp_err}, {31'h0, cur.err});
        end
        in_rsp = 1;
      end else begin
        chk("rsp_rdata_stable", {8'h00, rsp_rdata}, {8'h00, cur.rdata});
        chk("rsp_err_stable", {31'h0, rsp_err}, {31'h0, cur.err});
      end
      if (rsp_ready) in_rsp = 0;
    end
  end

  // Drive one request; caller and return both sit just after a posedge.
  // lat is the number of cycles after the accept edge until rsp_valid.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [23:0] addr, input logic [23:0] wd,
                       input logic [23:0] exp_rd, input logic exp_err,
                       input int lat, input bit push, output int acc);
    bit   rdy;
    bit   done = 0;
    exp_t e;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    acc        = -1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1;
    end
    req_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: request at %0h never accepted", addr);
    end else begin
      acc = cyc;
      if (push) begin
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.cyc   = acc + lat - 1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !rsp_valid) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL drain_timeout: %0d responses still outstanding", sb.size());
  endtask

  task automatic ld(input logic [1:0] sz, input logic sg, input logic [23:0] addr,
                    input logic [23:0] exp_rd, input logic exp_err, input int lat);
    int a;
    issue(1'b0, sz, sg, addr, 24'h0, exp_rd, exp_err, lat, 1'b1, a);
    wait_done();
  endtask

  task automatic st(input logic [1:0] sz, input logic [23:0] addr, input logic [23:0] wd,
                    input logic exp_err, input int lat);
    int a;
    issue(1'b1, sz, 1'b0, addr, wd, 24'h0, exp_err, lat, 1'b1, a);
    wait_done();
  endtask

  int w0, acc1, acc2, c_rel;

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = 24'h0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    mem[4] = 8'h0A;
    mem[5] = 8'h08;
    for (int i = 6; i < 32; i++) mem[i] = 8'h02;

    #3;
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("reset_dm_wen", {31'h0, dm_wen}, 32'h0);
    chk("reset_rsp_rdata", {8'h0, rsp_rdata}, 32'h0);
    chk("reset_dm_add", {8'h0, dm_add}, 32'h0);
    chk("reset_dm_data_in", {8'h0, dm_data_in}, 32'h0);
    chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Loads from the preloaded image
    w0 = wen_cnt;
    ld(2'd2, 1'b0, 24'd4, 24'h0A0802, 1'b0, 2);
    ld(2'd1, 1'b1, 24'd4, 24'h000A08, 1'b0, 2);
    chk("load_no_wen", wen_cnt - w0, 0);

    // Partial byte store: read-modify-write
    w0 = wen_cnt;
    st(2'd0, 24'd5, 24'h0000FF, 1'b0, 3);
    chk("bstore_wen_count", wen_cnt - w0, 1);
    chk("bstore_wen_add", {8'h0, wen_add}, 32'd5);
    chk("bstore_wen_data", {8'h0, wen_data}, 32'hFF0202);
    ld(2'd2, 1'b0, 24'd4, 24'h0AFF02, 1'b0, 2);

    // Extension variants after the store
    ld(2'd0, 1'b1, 24'd5, 24'hFFFFFF, 1'b0, 2);
    ld(2'd0, 1'b0, 24'd5, 24'h0000FF, 1'b0, 2);
    ld(2'd1, 1'b1, 24'd4, 24'h000AFF, 1'b0, 2);

    // Word store then half store merging into it
    w0 = wen_cnt;
    st(2'd2, 24'd8, 24'h123456, 1'b0, 2);
    chk("wstore_wen_data", {8'h0, wen_data}, 32'h123456);
    st(2'd1, 24'd10, 24'h00ABCD, 1'b0, 3);
    chk("hstore_wen_data", {8'h0, wen_data}, 32'hABCD02);
    chk("stores_wen_count", wen_cnt - w0, 2);
    ld(2'd2, 1'b0, 24'd8, 24'h1234AB, 1'b0, 2);
    ld(2'd1, 1'b1, 24'd9, 24'h0034AB, 1'b0, 2);
    ld(2'd1, 1'b1, 24'd10, 24'hFFABCD, 1'b0, 2);

    // Range and size checks at the top of memory
    w0 = wen_cnt;
    ld(2'd2, 1'b0, 24'd254, 24'h000000, 1'b1, 1);
    ld(2'd1, 1'b0, 24'd254, 24'h000000, 1'b0, 2);
    ld(2'd3, 1'b0, 24'd0, 24'h000000, 1'b1, 1);
    ld(2'd0, 1'b0, 24'd255, 24'h000000, 1'b0, 2);
    ld(2'd0, 1'b0, 24'd256, 24'h000000, 1'b1, 1);
    ld(2'd2, 1'b1, 24'hFFFFFF, 24'h000000, 1'b1, 1);
    st(2'd2, 24'd254, 24'hABCDEF, 1'b1, 1);
    st(2'd3, 24'd4, 24'hABCDEF, 1'b1, 1);
    chk("err_no_wen", wen_cnt - w0, 0);

    // Response stall with a queued request behind it
    rsp_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 24'd4, 24'h0, 24'h0AFF02, 1'b0, 2, 1'b1, acc1);
    c_rel = -1;
    fork
      begin
        issue(1'b0, 2'd2, 1'b0, 24'd8, 24'h0, 24'h1234AB, 1'b0, 2, 1'b1, acc2);
      end
      begin
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
          @(negedge clk);
          if (rsp_valid) seen = 1;
        end
        chk("stall_rsp_seen", {31'h0, seen}, 32'h1);
        for (int i = 0; i < 3; i++) begin
          chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
          chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
          @(posedge clk);
          #1;
          if (i < 2) @(negedge clk);
        end
        rsp_ready = 1'b1;
        c_rel = cyc;
      end
    join
    chk("stall_next_accept_cycle", acc2, c_rel + 2);
    wait_done();

    // Reset asserted while a partial store is in READ
    w0 = wen_cnt;
    issue(1'b1, 2'd0, 1'b0, 24'd20, 24'h000055, 24'h0, 1'b0, 3, 1'b0, acc1);
    chk("rst_mid_dm_add_before", {8'h0, dm_add}, 32'd20);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_mid_dm_wen", {31'h0, dm_wen}, 32'h0);
    chk("rst_mid_dm_add", {8'h0, dm_add}, 32'h0);
    chk("rst_mid_dm_data_in", {8'h0, dm_data_in}, 32'h0);
    chk("rst_mid_rsp_rdata", {8'h0, rsp_rdata}, 32'h0);
    chk("rst_mid_rsp_err", {31'h0, rsp_err}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_mid_no_wen", wen_cnt - w0, 0);
    ld(2'd2, 1'b0, 24'd20, 24'h020202, 1'b0, 2);

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
